param_sync_fifo: RTL and testbench

PARAM_SYNC_FIFO -- requirements
Module: param_sync_fifo

---
 rtl/param_sync_fifo_if.sv | 27 ++
 rtl/param_sync_fifo.sv | 58 +++++
 tb/tb_param_sync_fifo.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/param_sync_fifo_if.sv
// param_sync_fifo_if: write/read handshake, data and status bundle for param_sync_fifo.
interface param_sync_fifo_if #(
    parameter int WIDTH = 6,
    parameter int DEPTH = 32
);
    localparam int AW = $clog2(DEPTH);
    logic             wr_en;
    logic [WIDTH-1:0] data_in;
    logic             rd_en;
    logic [WIDTH-1:0] data_out;
    logic             data_valid;
    logic             full;
    logic             empty;
    logic             almost_full;
    logic             almost_empty;
    logic [AW:0]      count;
    logic             overflow;
    logic             underflow;
    modport master (
        output wr_en, data_in, rd_en,
        input  data_out, data_valid, full, empty, almost_full, almost_empty, count, overflow, underflow
    );
    modport slave (
        input  wr_en, data_in, rd_en,
        output data_out, data_valid, full, empty, almost_full, almost_empty, count, overflow, underflow
    );
endinterface

// File: rtl/param_sync_fifo.sv
// param_sync_fifo: single-clock FIFO with registered read data and occupancy-based status flags.
module param_sync_fifo #(
    parameter int WIDTH    = 6,
    parameter int DEPTH    = 32,
    parameter int AF_LEVEL = DEPTH - 2,
    parameter int AE_LEVEL = 2
) (
    input logic              clk,
    input logic              rst_n,
    param_sync_fifo_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_N = (AW+1)'(DEPTH);
    localparam logic [AW:0] AF_N   = (AW+1)'(AF_LEVEL);
    localparam logic [AW:0] AE_N   = (AW+1)'(AE_LEVEL);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [AW:0]      count;
    logic             wr_acc, rd_acc;

    // A write into a full FIFO is legal when a read frees a slot on the same edge
    assign rd_acc = bus.rd_en && count != '0;
    assign wr_acc = bus.wr_en && (count != FULL_N || rd_acc);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            count          <= '0;
            bus.data_out   <= '0;
            bus.data_valid <= 1'b0;
            bus.overflow   <= 1'b0;
            bus.underflow  <= 1'b0;
        end else begin
            if (wr_acc) wr_ptr <= wr_ptr + AW'(1);
            if (rd_acc) begin
                rd_ptr       <= rd_ptr + AW'(1);
                bus.data_out <= mem[rd_ptr];
            end
            count          <= count + (AW+1)'(wr_acc) - (AW+1)'(rd_acc);
            bus.data_valid <= rd_acc;
            bus.overflow   <= bus.wr_en && !wr_acc;
            bus.underflow  <= bus.rd_en && !rd_acc;
        end
    end

    // Storage is deliberately left unreset
    always_ff @(posedge clk) begin
        if (wr_acc && rst_n) mem[wr_ptr] <= bus.data_in;
    end

    assign bus.count        = count;
    assign bus.full         = count == FULL_N;
    assign bus.empty        = count == '0;
    assign bus.almost_full  = count >= AF_N;
    assign bus.almost_empty = count <= AE_N;
endmodule

// File: tb/tb_param_sync_fifo.sv
// tb_param_sync_fifo: scoreboard bench for a default (6x32) and an overridden (16x8) FIFO.
module tb_param_sync_fifo;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    param_sync_fifo_if #(.WIDTH(6), .DEPTH(32)) a ();
    param_sync_fifo_if #(.WIDTH(16), .DEPTH(8)) b ();

    param_sync_fifo u_a (.clk(clk), .rst_n(rst_n), .bus(a));
    param_sync_fifo #(.WIDTH(16), .DEPTH(8), .AF_LEVEL(6), .AE_LEVEL(1)) u_b (.clk(clk), .rst_n(rst_n), .bus(b));

    logic [5:0]  mq_a[$], exp_a[$];
    logic [15:0] mq_b[$], exp_b[$];
    logic [5:0]  last_a = '0;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Monitors: pop the expected word whenever a DUT presents valid data
    always @(negedge clk) begin
        if (a.data_valid) begin
            tests++;
            if (exp_a.size() == 0) begin
                fails++;
                $display("FAIL data_a: unexpected data_valid, got %h", a.data_out);
            end else begin
                logic [5:0] e;
                e = exp_a.pop_front();
                if (a.data_out !== e) begin
                    fails++;
                    $display("FAIL data_a: got %h expected %h at %0t", a.data_out, e, $time);
                end
            end
        end
        if (b.data_valid) begin
            tests++;
            if (exp_b.size() == 0) begin
                fails++;
                $display("FAIL data_b: unexpected data_valid, got %h", b.data_out);
            end else begin
                logic [15:0] e;
                e = exp_b.pop_front();
                if (b.data_out !== e) begin
                    fails++;
                    $display("FAIL data_b: got %h expected %h at %0t", b.data_out, e, $time);
                end
            end
        end
    end

    task automatic cyc_a(input logic w, input logic [5:0] d, input logic r);
        int  n;
        bit  ra, wa;
        n  = mq_a.size();
        ra = r && n > 0;
        wa = w && (n < 32 || ra);
        a.wr_en = w; a.data_in = d; a.rd_en = r;
        if (ra) begin
            last_a = mq_a.pop_front();
            exp_a.push_back(last_a);
        end
        if (wa) mq_a.push_back(d);
        @(posedge clk); #1;
        a.wr_en = 0; a.rd_en = 0;
        n = mq_a.size();
        chk("count_a", int'(a.count), n);
        chk("full_a", int'(a.full), int'(n == 32));
        chk("empty_a", int'(a.empty), int'(n == 0));
        chk("afull_a", int'(a.almost_full), int'(n >= 30));
        chk("aempty_a", int'(a.almost_empty), int'(n <= 2));
        chk("ovf_a", int'(a.overflow), int'(w && !wa));
        chk("unf_a", int'(a.underflow), int'(r && !ra));
        chk("dv_a", int'(a.data_valid), int'(ra));
    endtask

    task automatic cyc_b(input logic w, input logic [15:0] d, input logic r);
        int n;
        bit ra, wa;
        n  = mq_b.size();
        ra = r && n > 0;
        wa = w && (n < 8 || ra);
        b.wr_en = w; b.data_in = d; b.rd_en = r;
        if (ra) exp_b.push_back(mq_b.pop_front());
        if (wa) mq_b.push_back(d);
        @(posedge clk); #1;
        b.wr_en = 0; b.rd_en = 0;
        n = mq_b.size();
        chk("count_b", int'(b.count), n);
        chk("full_b", int'(b.full), int'(n == 8));
        chk("afull_b", int'(b.almost_full), int'(n >= 6));
        chk("aempty_b", int'(b.almost_empty), int'(n <= 1));
        chk("ovf_b", int'(b.overflow), int'(w && !wa));
    endtask

    task automatic rst_chk_a(input string tag);
        chk({tag, "_count"}, int'(a.count), 0);
        chk({tag, "_dout"}, int'(a.data_out), 0);
        chk({tag, "_dv"}, int'(a.data_valid), 0);
        chk({tag, "_ovf"}, int'(a.overflow), 0);
        chk({tag, "_unf"}, int'(a.underflow), 0);
        chk({tag, "_empty"}, int'(a.empty), 1);
        chk({tag, "_aempty"}, int'(a.almost_empty), 1);
        chk({tag, "_full"}, int'(a.full), 0);
        chk({tag, "_afull"}, int'(a.almost_full), 0);
    endtask

    initial begin
        a.wr_en = 0; a.rd_en = 0; a.data_in = '0;
        b.wr_en = 0; b.rd_en = 0; b.data_in = '0;
        #1 rst_chk_a("por");
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk); #1;

        // In-order write then read of 5 words
        for (int i = 1; i <= 5; i++) cyc_a(1, 6'(i), 0);
        for (int i = 0; i < 5; i++) cyc_a(0, '0, 1);
        cyc_a(0, '0, 0);
        chk("last_read", int'(a.data_out), 5);

        // Empty-side boundaries
        cyc_a(0, '0, 1);
        chk("hold_dout", int'(a.data_out), int'(last_a));
        cyc_a(1, 6'h11, 1);
        cyc_a(0, '0, 1);
        cyc_a(0, '0, 0);

        // Fill to full, overflow, then the first read must return word 1
        for (int i = 1; i <= 32; i++) cyc_a(1, 6'(i), 0);
        cyc_a(1, 6'h3F, 0);
        cyc_a(0, '0, 0);
        cyc_a(0, '0, 1);
        cyc_a(1, 6'h21, 0);

        // Full with simultaneous read/write across pointer wrap
        for (int i = 0; i < 40; i++) cyc_a(1, 6'(i + 34), 1);
        for (int i = 0; i < 32; i++) cyc_a(0, '0, 1);
        cyc_a(0, '0, 0);

        // Overridden instance thresholds
        for (int i = 0; i < 9; i++) cyc_b(1, 16'hA000 + 16'(i), 0);
        for (int i = 0; i < 8; i++) cyc_b(0, '0, 1);
        cyc_b(0, '0, 0);

        // Mid-cycle reset with entries loaded
        for (int i = 0; i < 10; i++) cyc_a(1, 6'(i + 7), 0);
        #3 rst_n = 1'b0;
        #1 rst_chk_a("rst");
        mq_a.delete();
        a.wr_en = 1; a.rd_en = 1; a.data_in = 6'h15;
        @(posedge clk); #1;
        a.wr_en = 0; a.rd_en = 0;
        rst_chk_a("rst_edge");
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_empty", int'(a.empty), 1);
        cyc_a(1, 6'h2A, 0);
        cyc_a(0, '0, 1);
        cyc_a(0, '0, 0);
        chk("post_rst_dout", int'(a.data_out), 'h2A);

        chk("sb_a_drained", exp_a.size(), 0);
        chk("sb_b_drained", exp_b.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
